// File: rtl/mfreg_arbiter.sv
// mfreg_arbiter
// ----------------------------------------------------------------------------
// Round-robin arbiter and sequencer that sits between four requesters and one
// N-bit multi-function register (shift right / increment / load). One
// requester is granted at a time. Its mode, data and repeat count are latched
// at grant time. The register is then driven with a train of single-cycle
// enable pulses, each followed by at least one low cycle. The requester is
// acknowledged when the train completes.
//
// Handshake (Req/Ack): Req[i] is a level that the requester holds until it
// sees Ack[i]. Req is sampled only while idle. Once a request is granted,
// later changes on Req, ModeIn, DataIn or CntIn have no effect on that
// transaction. Ack[i] is a one-cycle pulse that marks completion. A requester
// that keeps Req high after its Ack is served again, but it goes to the back
// of the round-robin order.
//
// Ports:
//   CLK       in   1    system clock, rising edge
//   RST       in   1    asynchronous, active-high reset
//   Req       in   4    request level per requester
//   ModeIn    in   8    mode per requester, [2i+1:2i]
//                       (01 shift, 10 inc, 11 load, 00 no-op)
//   DataIn    in   4N   load data per requester, [N*i+N-1:N*i]
//   CntIn     in   16   repeat count per requester, [4i+3:4i] (0 means 16)
//   RegEn     out  1    register ClockEn, one cycle high per operation
//   RegM      out  2    register mode
//   RegDin    out  N    register data in
//   Grant     out  4    one-hot requester being served, 0 when idle
//   Ack       out  4    one-hot, single-cycle completion pulse
//   Busy      out  1    high whenever not idle
//   dbg_state out  2    current FSM state, for observation only
// ----------------------------------------------------------------------------
module mfreg_arbiter #(
    parameter int N = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [3:0]     Req,
    input  logic [7:0]     ModeIn,
    input  logic [4*N-1:0] DataIn,
    input  logic [15:0]    CntIn,
    output logic           RegEn,
    output logic [1:0]     RegM,
    output logic [N-1:0]   RegDin,
    output logic [3:0]     Grant,
    output logic [3:0]     Ack,
    output logic           Busy,
    output logic [1:0]     dbg_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]   state;
    logic [1:0]   last;       // most recently served requester
    logic [4:0]   remaining;  // operations still to issue, up to 16
    logic [3:0]   grant_q;

    logic         pick_valid;
    logic [1:0]   pick_idx;
    logic [1:0]   pick_mode;
    logic [N-1:0] pick_data;
    logic [3:0]   pick_cnt;

    // Scan last+1, last+2, last+3 and finally last itself. The requester
    // that was just served therefore has the lowest priority.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = last;
        for (int k = 1; k <= 4; k++) begin
            if (!pick_valid && Req[last + 2'(k)]) begin
                pick_valid = 1'b1;
                pick_idx   = last + 2'(k);
            end
        end
        pick_mode = ModeIn[2*pick_idx +: 2];
        pick_data = DataIn[N*pick_idx +: N];
        pick_cnt  = CntIn[4*pick_idx +: 4];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            last      <= 2'd3;
            remaining <= 5'd0;
            grant_q   <= 4'b0000;
            RegM      <= 2'b00;
            RegDin    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q   <= 4'b0001 << pick_idx;
                        RegM      <= pick_mode;
                        RegDin    <= pick_data;
                        // A count field of 0 encodes the maximum train of 16.
                        remaining <= (pick_cnt == 4'd0) ? 5'd16 : {1'b0, pick_cnt};
                        state     <= (pick_mode == 2'b00) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    remaining <= remaining - 5'd1;
                    state     <= GAP;
                end
                GAP: begin
                    // The low cycle always comes after a pulse, so each
                    // operation gives the register a fresh rising enable.
                    state <= (remaining == 5'd0) ? DONE : ISSUE;
                end
                DONE: begin
                    for (int i = 0; i < 4; i++) begin
                        if (grant_q[i]) last <= 2'(i);
                    end
                    grant_q <= 4'b0000;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore decodes. An asynchronous reset clears state and grant_q, so all
    // of these drop at once, even in the middle of a train.
    assign RegEn     = (state == ISSUE);
    assign Busy      = (state != IDLE);
    assign Ack       = (state == DONE) ? grant_q : 4'b0000;
    assign Grant     = grant_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_mfreg_arbiter.sv
module tb_mfreg_arbiter;

    localparam int N = 4;

    logic           CLK = 1'b0;
    logic           RST;
    logic [3:0]     Req;
    logic [7:0]     ModeIn;
    logic [4*N-1:0] DataIn;
    logic [15:0]    CntIn;
    logic           RegEn;
    logic [1:0]     RegM;
    logic [N-1:0]   RegDin;
    logic [3:0]     Grant;
    logic [3:0]     Ack;
    logic           Busy;
    logic [1:0]     dbg_state;

    int total = 0;
    int bad   = 0;
    int model_last = 3;
    int txn_no = 0;
    logic [N-1:0] reg_obs;   // register driven by the DUT's outputs
    logic [N-1:0] reg_exp;   // register effect predicted arithmetically

    mfreg_arbiter #(.N(N)) dut (
        .CLK(CLK), .RST(RST), .Req(Req), .ModeIn(ModeIn), .DataIn(DataIn),
        .CntIn(CntIn), .RegEn(RegEn), .RegM(RegM), .RegDin(RegDin),
        .Grant(Grant), .Ack(Ack), .Busy(Busy), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise reset between edges and check that every output clears at once.
    task automatic do_reset(input string tag);
        RST = 1'b1;
        #1;
        check(tag, {Grant, Ack, RegEn, Busy, RegM, RegDin}, 32'd0);
        tick();
        RST = 1'b0;
        model_last = 3;
        reg_obs = '0;
        reg_exp = '0;
    endtask

    // The pulses the bench register sees, applied one at a time.
    task automatic apply_observed();
        if (RegEn) begin
            case (RegM)
                2'b01: reg_obs = reg_obs >> 1;
                2'b10: reg_obs = reg_obs + 1'b1;
                2'b11: reg_obs = RegDin;
                default: ;
            endcase
        end
    endtask

    // Drive one transaction from idle. The reference model picks the winner
    // by round-robin arithmetic and derives the expected cycle-by-cycle trace
    // from the effective count: pulses after odd edges up to 2C-1, Ack after
    // edge 2C+1, and idle after edge 2C+2. With mode 00, Ack comes after edge 1
    // and idle after edge 2.
    task automatic run_txn(input logic [3:0] rq, input logic [7:0] md,
                           input logic [15:0] dt, input logic [15:0] ct,
                           input bit scramble);
        int w;
        int j;
        int c_eff;
        int len;
        logic [1:0]   m;
        logic [N-1:0] d;
        logic [3:0]   cr;
        logic [3:0]   eg;
        logic [3:0]   ea;
        logic         een;
        Req = rq; ModeIn = md; DataIn = dt; CntIn = ct;
        txn_no++;
        w = -1;
        for (int k = 1; k <= 4; k++) begin
            j = (model_last + k) % 4;
            if (w < 0 && rq[j]) w = j;
        end
        if (w < 0) begin
            tick();
            check($sformatf("txn%0d_noreq", txn_no), {Grant, Ack, RegEn, Busy}, 32'd0);
            return;
        end
        m  = md[2*w +: 2];
        d  = dt[N*w +: N];
        cr = ct[4*w +: 4];
        c_eff = (cr == 4'd0) ? 16 : int'(cr);
        len = (m == 2'b00) ? 2 : 2*c_eff + 2;
        case (m)
            2'b01: reg_exp = reg_exp >> c_eff;
            2'b10: reg_exp = reg_exp + N'(c_eff);
            2'b11: reg_exp = d;
            default: ;
        endcase
        for (int k = 1; k <= len; k++) begin
            tick();
            eg  = (k < len) ? 4'(1 << w) : 4'b0000;
            ea  = (k == len - 1) ? 4'(1 << w) : 4'b0000;
            een = (m != 2'b00) && (k % 2 == 1) && (k <= 2*c_eff - 1);
            check($sformatf("txn%0d_ctl_k%0d", txn_no, k),
                  {Grant, Ack, RegEn, Busy}, {eg, ea, een, 1'(k < len)});
            check($sformatf("txn%0d_dp_k%0d", txn_no, k), {RegM, RegDin}, {m, d});
            apply_observed();
            if (k == 1 && scramble) begin
                Req    = 4'($urandom);
                ModeIn = 8'($urandom);
                DataIn = 16'($urandom);
                CntIn  = 16'($urandom);
            end
        end
        check($sformatf("txn%0d_register", txn_no), 32'(reg_obs), 32'(reg_exp));
        model_last = w;
    endtask

    initial begin
        RST = 1'b1; Req = '0; ModeIn = '0; DataIn = '0; CntIn = '0;
        reg_obs = '0; reg_exp = '0;

        // reset state
        do_reset("reset_initial");

        // single load on requester 0
        run_txn(4'b0001, 8'b00_00_00_11, 16'h000A, 16'h0001, 1'b0);

        // repeat: requester 1, increment x3, from 0 to 3
        reg_obs = '0; reg_exp = '0;
        run_txn(4'b0010, 8'b00_00_10_00, 16'h0000, 16'h0030, 1'b0);
        check("repeat_final_value", 32'(reg_obs), 32'd3);

        // fairness 0101 then 1111
        do_reset("reset_before_fair");
        for (int i = 0; i < 4; i++)
            run_txn(4'b0101, 8'b11_11_11_11, 16'h4321, 16'h1111, 1'b0);
        do_reset("reset_before_fair4");
        for (int i = 0; i < 5; i++)
            run_txn(4'b1111, 8'b10_01_11_10, 16'h9876, 16'h2121, 1'b0);

        // mode 00 with count 5 on requester 3
        run_txn(4'b1000, 8'b00_11_11_11, 16'hF000, 16'h5000, 1'b0);

        // count 0 on requester 2, shift right: 16 pulses
        reg_obs = 4'hF; reg_exp = 4'hF;
        run_txn(4'b0100, 8'b00_01_00_00, 16'h0000, 16'h0000, 1'b0);

        // reset mid-stream with all requests held, then 0 wins first
        Req = 4'b1111; ModeIn = 8'hFF; DataIn = 16'h5555; CntIn = 16'h3333;
        for (int i = 0; i < 3; i++) tick();
        do_reset("reset_midstream");
        run_txn(4'b1111, 8'b11_11_11_11, 16'hABCD, 16'h1111, 1'b0);

        // abort a count-0 train during its 3rd pulse: no Ack afterwards
        Req = 4'b0100; ModeIn = 8'b00_01_00_00; DataIn = 16'h0000; CntIn = 16'h0000;
        for (int i = 0; i < 5; i++) tick();
        check("abort_third_pulse", {Grant, RegEn, Busy}, {4'b0100, 1'b1, 1'b1});
        Req = 4'b0000;
        do_reset("reset_abort");
        for (int i = 0; i < 40; i++) begin
            tick();
            check($sformatf("abort_quiet_%0d", i), {Ack, Busy, RegEn}, 32'd0);
        end

        // randomized transactions with inputs scrambled mid-service
        for (int i = 0; i < 40; i++)
            run_txn(4'($urandom_range(0, 15)), 8'($urandom), 16'($urandom),
                    16'($urandom), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
